// File: rtl/mod_mem_pkg.sv
// Shared types and limits for the synchronous word memory and its read pipe.
// No logic; constants only.
package mod_mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mod_mem_rdpipe.sv
// Read-response delay line: valid, error and data stages, RD_LAT deep.
// Latency RD_LAT cycles from in_* to out_*; no backpressure, one entry per cycle.
// Data and error are forced to zero in any stage that does not hold a response.
module mod_mem_rdpipe
    import mod_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld_i,
    input  logic              in_err_i,
    input  logic [DATA_W-1:0] in_dat_i,
    output logic              out_vld_o,
    output logic              out_err_o,
    output logic [DATA_W-1:0] out_dat_o
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $fatal(1, "mod_mem_rdpipe: RD_LAT must be within 1..4");
    end

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] err_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                dat_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld_i;
            err_q[0] <= in_vld_i & in_err_i;
            dat_q[0] <= in_vld_i ? in_dat_i : '0;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                err_q[s] <= err_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign out_vld_o = vld_q[RD_LAT-1];
    assign out_err_o = err_q[RD_LAT-1];
    assign out_dat_o = dat_q[RD_LAT-1];

endmodule

// File: rtl/mod_mem_sync.sv
// Byte-enabled synchronous word memory with pipelined reads and a zero-fill sweep.
// Read response RD_LAT cycles after the accept edge; writes produce no response.
// req_ready_o low while clearing or when a clear is requested; reads never stall.
module mod_mem_sync
    import mod_mem_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 32768,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    input  logic                  clr_start_i,
    output logic                  clr_busy_o
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
        $fatal(1, "mod_mem_sync: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
        $fatal(1, "mod_mem_sync: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
    end

    state_e            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              clr_busy_q;
    logic              rdy_en_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  clr_idx;

    logic              rd_vld_d, rd_vld_q;
    logic              rd_err_d, rd_err_q;
    logic [DATA_W-1:0] rd_dat_d, rd_dat_q;

    // rdy_en_q holds ready low until the first edge after reset release.
    assign req_ready_o = (state_q == ST_IDLE) && !clr_start_i && rst_n && rdy_en_q;
    assign accept      = req_valid_i && req_ready_o;
    assign in_range    = {1'b0, req_addr_i} < DEPTH_V;
    assign req_idx     = req_addr_i[IDX_W-1:0];
    assign clr_idx     = clr_addr_q[IDX_W-1:0];
    assign clr_busy_o  = clr_busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            clr_busy_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (clr_start_i) begin
                        state_q    <= ST_CLEAR;
                        clr_addr_q <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= ST_IDLE;
                        clr_busy_q <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Array contents survive reset; the sweep and requests never overlap.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_idx] <= '0;
        end else if (accept && req_we_i && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be_i[b]) begin
                    mem_q[req_idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_vld_d = accept && !req_we_i;
        rd_err_d = rd_vld_d && !in_range;
        rd_dat_d = '0;
        if (rd_vld_d && in_range) begin
            rd_dat_d = mem_q[req_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            rd_err_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_err_q <= rd_err_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    mod_mem_rdpipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (rd_vld_q),
        .in_err_i  (rd_err_q),
        .in_dat_i  (rd_dat_q),
        .out_vld_o (rsp_valid_o),
        .out_err_o (rsp_err_o),
        .out_dat_o (rsp_rdata_o)
    );

endmodule

// File: tb/tb_mod_mem_sync.sv
// Scoreboard bench for mod_mem_sync: three instances with different depth/latency.
// Stimulus pushes expected read responses; a negedge monitor pops and compares.
module tb_mod_mem_sync;

    localparam int NI = 3;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        rst_n       [NI];
    logic        req_valid   [NI];
    logic        req_ready   [NI];
    logic        req_we      [NI];
    logic [9:0]  req_addr    [NI];
    logic [31:0] req_wdata   [NI];
    logic [3:0]  req_be      [NI];
    logic        rsp_valid   [NI];
    logic [31:0] rsp_rdata   [NI];
    logic        rsp_err     [NI];
    logic        clr_start   [NI];
    logic        clr_busy    [NI];

    exp_t        exp_q [NI][$];
    logic [31:0] cyc;
    int          total_cnt;
    int          pass_cnt;
    exp_t        mon_e;

    // inst 0: DEPTH 1000, RD_LAT 2; inst 1: DEPTH 16, RD_LAT 3; inst 2: DEPTH 16, RD_LAT 4
    mod_mem_sync #(.ADDR_W(10), .DEPTH(1000), .DATA_W(32), .RD_LAT(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]),
        .clr_start_i(clr_start[0]), .clr_busy_o(clr_busy[0])
    );

    mod_mem_sync #(.ADDR_W(10), .DEPTH(16), .DATA_W(32), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]),
        .clr_start_i(clr_start[1]), .clr_busy_o(clr_busy[1])
    );

    mod_mem_sync #(.ADDR_W(10), .DEPTH(16), .DATA_W(32), .RD_LAT(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_we_i(req_we[2]),
        .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]), .req_be_i(req_be[2]),
        .rsp_valid_o(rsp_valid[2]), .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]),
        .clr_start_i(clr_start[2]), .clr_busy_o(clr_busy[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL inst%0d %s: got 0x%08h expected 0x%08h (t=%0t)", i, name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rsp_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk(i, "rsp_unexpected", 32'(1), 32'(0));
                end else begin
                    mon_e = exp_q[i].pop_front();
                    chk(i, "rsp_rdata", rsp_rdata[i], mon_e.dat);
                    chk(i, "rsp_err", 32'(rsp_err[i]), 32'(mon_e.err));
                    chk(i, "rsp_cycle", cyc, mon_e.cyc);
                end
            end else begin
                chk(i, "rsp_idle_zero", rsp_rdata[i] | 32'(rsp_err[i]), 32'(0));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a request; leaves it asserted so back-to-back calls issue every cycle.
    task automatic drive(input int i, input logic we, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit push, input logic [31:0] ed, input logic ee);
        exp_t e;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_be[i]    = be;
        @(negedge clk);
        chk(i, "req_ready", 32'(req_ready[i]), 32'(1));
        @(posedge clk);
        #1;
        if (push && !we) begin
            e.dat = ed;
            e.err = ee;
            e.cyc = cyc + 32'(lat_of(i));
            exp_q[i].push_back(e);
        end
    endtask

    task automatic wr(input int i, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        drive(i, 1'b1, a, d, be, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input int i, input logic [9:0] a, input logic [31:0] ed, input logic ee);
        drive(i, 1'b0, a, '0, '0, 1'b1, ed, ee);
    endtask

    task automatic idle(input int i);
        req_valid[i] = 1'b0;
        req_we[i]    = 1'b0;
        req_be[i]    = '0;
    endtask

    task automatic do_clear(input int i, input int exp_len, input bit pulse_mid);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        clr_start[i] = 1'b1;
        @(negedge clk);
        chk(i, "ready_vs_clr_start", 32'(req_ready[i]), 32'(0));
        @(posedge clk);
        #1;
        clr_start[i] = 1'b0;
        req_valid[i] = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!clr_busy[i]) break;
            n++;
            if (req_ready[i]) bad++;
            clr_start[i] = pulse_mid && (n == exp_len / 2);
        end
        clr_start[i] = 1'b0;
        chk(i, "clr_busy_cycles", 32'(n), 32'(exp_len));
        chk(i, "ready_during_clear", 32'(bad), 32'(0));
        step(1);
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        for (int i = 0; i < NI; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_be[i]    = '0;
            clr_start[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk(i, "reset_ready", 32'(req_ready[i]), 32'(0));
            chk(i, "reset_busy", 32'(clr_busy[i]), 32'(0));
            chk(i, "reset_rsp_valid", 32'(rsp_valid[i]), 32'(0));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk(i, "ready_before_first_edge", 32'(req_ready[i]), 32'(0));
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk(i, "ready_after_first_edge", 32'(req_ready[i]), 32'(1));
        step(1);

        // Instance 0: known contents, single-lane write, lane merge, range limits.
        do_clear(0, 1000, 1'b0);
        wr(0, 10'h010, 32'h0000_00A5, 4'b0001);
        rd(0, 10'h010, 32'h0000_00A5, 1'b0);
        wr(0, 10'h020, 32'h1122_3344, 4'b1111);
        wr(0, 10'h020, 32'hFFFF_FFFF, 4'b0101);
        rd(0, 10'h020, 32'h11FF_33FF, 1'b0);
        wr(0, 10'd0,    32'hCAFE_F00D, 4'b1111);
        wr(0, 10'd1023, 32'hDEAD_BEEF, 4'b1111);
        rd(0, 10'd1023, 32'h0000_0000, 1'b1);
        rd(0, 10'd0,    32'hCAFE_F00D, 1'b0);
        wr(0, 10'd999,  32'h0000_0099, 4'b1111);
        wr(0, 10'd1000, 32'h1234_5678, 4'b1111);
        rd(0, 10'd999,  32'h0000_0099, 1'b0);
        rd(0, 10'd1000, 32'h0000_0000, 1'b1);
        rd(0, 10'd0,    32'hCAFE_F00D, 1'b0);
        idle(0);

        // Instance 1: back-to-back reads, clear priority, in-flight read survives clear.
        for (int k = 0; k < 16; k++) wr(1, 10'(k), 32'h40 + 32'(k), 4'b1111);
        for (int k = 0; k < 8; k++)  rd(1, 10'(k), 32'h40 + 32'(k), 1'b0);
        idle(1);
        step(1);
        rd(1, 10'd5, 32'h0000_0045, 1'b0);
        req_addr[1] = 10'd6;
        do_clear(1, 16, 1'b1);
        for (int k = 0; k < 16; k++) rd(1, 10'(k), 32'h0, 1'b0);
        idle(1);

        // Instance 2: reset one cycle into the sweep with two reads still in flight.
        for (int k = 0; k < 16; k++) wr(2, 10'(k), 32'h80 + 32'(k), 4'b1111);
        drive(2, 1'b0, 10'd1, '0, '0, 1'b0, '0, 1'b0);
        drive(2, 1'b0, 10'd2, '0, '0, 1'b0, '0, 1'b0);
        idle(2);
        clr_start[2] = 1'b1;
        step(1);
        clr_start[2] = 1'b0;
        step(1);
        rst_n[2] = 1'b0;
        @(negedge clk);
        chk(2, "abort_busy", 32'(clr_busy[2]), 32'(0));
        chk(2, "abort_ready", 32'(req_ready[2]), 32'(0));
        chk(2, "abort_rsp_valid", 32'(rsp_valid[2]), 32'(0));
        step(2);
        rst_n[2] = 1'b1;
        @(negedge clk);
        chk(2, "rerelease_ready_early", 32'(req_ready[2]), 32'(0));
        @(negedge clk);
        chk(2, "rerelease_ready", 32'(req_ready[2]), 32'(1));
        step(6);
        chk(2, "no_resumed_clear", 32'(clr_busy[2]), 32'(0));
        rd(2, 10'd0, 32'h0, 1'b0);
        for (int k = 1; k < 16; k++) rd(2, 10'(k), 32'h80 + 32'(k), 1'b0);
        idle(2);

        step(10);
        for (int i = 0; i < NI; i++) chk(i, "responses_outstanding", 32'(exp_q[i].size()), 32'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mod_mem_sync.md
MOD_MEM_SYNC -- requirements
Module: mod_mem_sync

Interface
REQ-001 Parameter ADDR_W, default 15, address width in bits.
REQ-002 Parameter DEPTH, default 32768, number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-003 Parameter DATA_W, default 8, word width; SHALL be a multiple of 8.
REQ-004 Parameter RD_LAT, default 2, read latency in cycles; legal range 1..4.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 REQ_VALID  in  1  request present.
REQ-008 REQ_READY  out  1  block accepts a request this cycle.
REQ-009 REQ_WE  in  1  1 = write, 0 = read.
REQ-010 REQ_ADDR  in  ADDR_W  word address.
REQ-011 REQ_WDATA  in  DATA_W  write data.
REQ-012 REQ_BE  in  DATA_W/8  byte-lane write enables; bit i covers lane i.
REQ-013 RSP_VALID  out  1  one-cycle read-response strobe.
REQ-014 RSP_RDATA  out  DATA_W  read data.
REQ-015 RSP_ERR  out  1  read address was >= DEPTH; qualified by RSP_VALID.
REQ-016 CLR_START  in  1  request a zero-fill of the whole array.
REQ-017 CLR_BUSY  out  1  zero-fill in progress.

Function
REQ-018 The FSM SHALL have two states: IDLE and CLEAR.
REQ-019 REQ_READY = (state == IDLE) && !CLR_START && RST_N.
REQ-020 A transfer SHALL occur on a rising edge where REQ_VALID && REQ_READY.
REQ-021 Write transfer: only lanes with REQ_BE[i]=1 SHALL update at that edge. Writes produce no response. A read accepted on the next cycle SHALL return the new data.
REQ-022 Write with REQ_ADDR >= DEPTH SHALL be discarded without side effects.
REQ-023 Read transfer: RSP_VALID SHALL assert exactly RD_LAT cycles after the accept edge, for one cycle, with RSP_RDATA = array contents as of the accept edge.
REQ-024 Reads SHALL be fully pipelined: one accept per cycle, responses in order, no bubbles.
REQ-025 Read with REQ_ADDR >= DEPTH SHALL return RSP_RDATA = 0 and RSP_ERR = 1.
REQ-026 When RSP_VALID = 0, RSP_RDATA SHALL be 0 and RSP_ERR SHALL be 0.
REQ-027 CLR_START high in IDLE SHALL enter CLEAR on the next edge. It SHALL then write 0 to addresses 0..DEPTH-1, one per cycle in ascending order, and return to IDLE after the DEPTH-th write.
REQ-028 CLR_BUSY SHALL be high exactly for the DEPTH cycles spent in CLEAR.
REQ-029 When CLR_START and REQ_VALID are both high in IDLE, the clear SHALL win and the request SHALL NOT be accepted.
REQ-030 Reads already in the pipeline when CLEAR begins SHALL complete with pre-clear data.
REQ-031 CLR_START during CLEAR SHALL be ignored; it does not restart the sweep.

Reset
REQ-032 While RST_N = 0: state = IDLE; REQ_READY, RSP_VALID, RSP_ERR and CLR_BUSY = 0; RSP_RDATA = 0; read pipeline flushed.
REQ-033 Array contents SHALL NOT be reset.
REQ-034 Reset during CLEAR SHALL abort the sweep; partially cleared contents remain.
REQ-035 Reset with reads in flight SHALL drop them; no RSP_VALID for those reads after release.
REQ-036 REQ_READY SHALL rise on the first edge after RST_N deasserts.

Structure
REQ-037 Package mod_mem_pkg SHALL hold the FSM state enumeration and the constants RD_LAT_MIN = 1 and RD_LAT_MAX = 4.
REQ-038 The read latency delay line (valid, error and data stages) SHALL be a sub-module, mod_mem_rdpipe, parametrised by DATA_W and RD_LAT.
REQ-039 Illegal parameters SHALL halt elaboration: RD_LAT outside 1..4, DATA_W % 8 != 0, or DEPTH > 2**ADDR_W.

Verification
REQ-040 Write 0xA5 at address 0x0010 (BE = 1), then read 0x0010 on the next cycle -> RSP_VALID exactly 2 cycles after accept, RSP_RDATA = 0xA5, RSP_ERR = 0.
REQ-041 DATA_W = 32: write 0x11223344 with BE = 1111, then 0xFFFFFFFF with BE = 0101 -> read returns 0x11FF33FF.
REQ-042 Eight back-to-back reads at addresses 0..7 with RD_LAT = 3 -> eight consecutive RSP_VALID cycles, data in order.
REQ-043 DEPTH = 1000, ADDR_W = 10: read at 1023 -> RSP_RDATA = 0, RSP_ERR = 1; write at 1023 leaves address 0 unchanged.
REQ-044 CLR_START together with REQ_VALID (DEPTH = 16) -> request not accepted; CLR_BUSY high for 16 cycles; all addresses then read 0.
REQ-045 RST_N low midway through CLEAR with 2 reads in flight -> no RSP_VALID afterwards; CLR_BUSY = 0; addresses past the abort point keep old data.
